// File: rtl/rep_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rep_sequencer_pkg
//  Description : Shared opcode, EFLAGS, FSM, REP-prefix and operand-size
//                encodings for the string-instruction REP sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rep_sequencer_pkg;

    localparam logic [6:0] CMD_NOP  = 7'h00;
    localparam logic [6:0] CMD_ADD  = 7'h01;
    localparam logic [6:0] CMD_SUB  = 7'h02;
    localparam logic [6:0] CMD_MOVS = 7'h20;
    localparam logic [6:0] CMD_CMPS = 7'h21;

    localparam int EFLAGS_ZF_BIT = 6;
    localparam int EFLAGS_DF_BIT = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] REP_NONE  = 2'b00;
    localparam logic [1:0] REP_E     = 2'b01;
    localparam logic [1:0] REP_NE    = 2'b10;
    localparam logic [1:0] REP_E_ALT = 2'b11;

    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_1B: size_bytes = 3'd1;
            SIZE_2B: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_str(input logic [6:0] opc);
        is_str = (opc == CMD_MOVS) || (opc == CMD_CMPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rep_sequencer_addr_step.sv
`default_nettype none
// ============================================================================
//  Module      : rep_addr_step
//  Description : Next string pointer: address +/- operand size, wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module rep_addr_step
    import rep_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        i_size,
    input  logic              i_df,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_step;

    assign w_step      = {{(ADDR_W-3){1'b0}}, size_bytes(i_size)};
    assign o_next_addr = i_df ? (i_addr - w_step) : (i_addr + w_step);

endmodule
`default_nettype wire

// File: rtl/rep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rep_sequencer
//  Description : Sequences REP/REPE/REPNE string instructions into single
//                iterations and reports final ECX/ESI/EDI/EFLAGS.
//  Revision    : 1.0 - initial release
// ============================================================================
module rep_sequencer
    import rep_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opc,
    input  logic [1:0]        in_rep,
    input  logic [1:0]        in_size,
    input  logic [ADDR_W-1:0] in_ecx,
    input  logic [ADDR_W-1:0] in_esi,
    input  logic [ADDR_W-1:0] in_edi,
    input  logic [31:0]       in_eflags,
    output logic              it_valid,
    input  logic              it_ready,
    output logic [6:0]        it_opc,
    output logic [ADDR_W-1:0] it_esi,
    output logic [ADDR_W-1:0] it_edi,
    output logic [31:0]       it_eflags,
    input  logic              it_rsp_valid,
    input  logic [31:0]       it_rsp_eflags,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [ADDR_W-1:0] done_ecx,
    output logic [ADDR_W-1:0] done_esi,
    output logic [ADDR_W-1:0] done_edi,
    output logic [31:0]       done_eflags,
    output logic [ADDR_W-1:0] done_iters
);

    localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q,  state_d;
    logic [6:0]        opc_q,    opc_d;
    logic [1:0]        rep_q,    rep_d;
    logic [1:0]        size_q,   size_d;
    logic              df_q,     df_d;
    logic [ADDR_W-1:0] ecx_q,    ecx_d;
    logic [ADDR_W-1:0] esi_q,    esi_d;
    logic [ADDR_W-1:0] edi_q,    edi_d;
    logic [31:0]       eflags_q, eflags_d;
    logic [ADDR_W-1:0] iters_q,  iters_d;

    logic              w_str;
    logic              w_cmps;
    logic              w_rep_eff;
    logic              w_zf;
    logic              w_term;
    logic [ADDR_W-1:0] w_ecx_dec;
    logic [ADDR_W-1:0] w_esi_next;
    logic [ADDR_W-1:0] w_edi_next;

    rep_addr_step #(.ADDR_W(ADDR_W)) u_step_esi (
        .i_size      (size_q),
        .i_df        (df_q),
        .i_addr      (esi_q),
        .o_next_addr (w_esi_next)
    );

    rep_addr_step #(.ADDR_W(ADDR_W)) u_step_edi (
        .i_size      (size_q),
        .i_df        (df_q),
        .i_addr      (edi_q),
        .o_next_addr (w_edi_next)
    );

    assign w_str     = is_str(opc_q);
    assign w_cmps    = (opc_q == CMD_CMPS);
    assign w_rep_eff = (rep_q != REP_NONE) && w_str;
    assign w_zf      = it_rsp_eflags[EFLAGS_ZF_BIT];
    assign w_ecx_dec = (w_rep_eff && (ecx_q != '0)) ? (ecx_q - C_ONE) : ecx_q;

    // REPNE stops on a match (ZF=1); REPE and its 2'b11 alias stop on a miss.
    assign w_term = !w_rep_eff || (w_ecx_dec == '0) ||
                    (w_cmps && ((rep_q == REP_NE) ? w_zf : !w_zf));

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        rep_d    = rep_q;
        size_d   = size_q;
        df_d     = df_q;
        ecx_d    = ecx_q;
        esi_d    = esi_q;
        edi_d    = edi_q;
        eflags_d = eflags_q;
        iters_d  = iters_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opc_d    = in_opc;
                    rep_d    = in_rep;
                    size_d   = in_size;
                    df_d     = in_eflags[EFLAGS_DF_BIT];
                    ecx_d    = in_ecx;
                    esi_d    = in_esi;
                    edi_d    = in_edi;
                    eflags_d = in_eflags;
                    iters_d  = '0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = (w_rep_eff && (ecx_q == '0)) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (it_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (it_rsp_valid) begin
                    eflags_d = it_rsp_eflags;
                    iters_d  = (&iters_q) ? iters_q : (iters_q + C_ONE);
                    ecx_d    = w_ecx_dec;
                    if (w_str) begin
                        esi_d = w_esi_next;
                        edi_d = w_edi_next;
                    end
                    state_d = w_term ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opc_q    <= '0;
            rep_q    <= '0;
            size_q   <= '0;
            df_q     <= 1'b0;
            ecx_q    <= '0;
            esi_q    <= '0;
            edi_q    <= '0;
            eflags_q <= '0;
            iters_q  <= '0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            rep_q    <= rep_d;
            size_q   <= size_d;
            df_q     <= df_d;
            ecx_q    <= ecx_d;
            esi_q    <= esi_d;
            edi_q    <= edi_d;
            eflags_q <= eflags_d;
            iters_q  <= iters_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign it_valid    = (state_q == ST_ISSUE);
    assign it_opc      = opc_q;
    assign it_esi      = esi_q;
    assign it_edi      = edi_q;
    assign it_eflags   = eflags_q;
    assign done_valid  = (state_q == ST_DONE);
    assign done_ecx    = ecx_q;
    assign done_esi    = esi_q;
    assign done_edi    = edi_q;
    assign done_eflags = eflags_q;
    assign done_iters  = iters_q;

endmodule
`default_nettype wire

// File: tb/tb_rep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rep_sequencer
//  Description : Scoreboard bench for rep_sequencer with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rep_sequencer;
    import rep_sequencer_pkg::*;

    typedef struct {
        logic [6:0]  opc;
        logic [31:0] esi;
        logic [31:0] edi;
        logic [31:0] eflags;
    } exp_it_t;

    typedef struct {
        logic [31:0] ecx;
        logic [31:0] esi;
        logic [31:0] edi;
        logic [31:0] eflags;
        logic [31:0] iters;
    } exp_done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opc = '0;
    logic [1:0]  in_rep = '0;
    logic [1:0]  in_size = '0;
    logic [31:0] in_ecx = '0, in_esi = '0, in_edi = '0, in_eflags = '0;
    logic        it_valid;
    logic        it_ready = 1'b1;
    logic [6:0]  it_opc;
    logic [31:0] it_esi, it_edi, it_eflags;
    logic        it_rsp_valid = 1'b0;
    logic [31:0] it_rsp_eflags = '0;
    logic        done_valid;
    logic        done_ready = 1'b1;
    logic [31:0] done_ecx, done_esi, done_edi, done_eflags, done_iters;

    int errors = 0;
    int checks = 0;

    exp_it_t     exp_it[$];
    exp_done_t   exp_done[$];
    logic [31:0] rsp_q[$];

    rep_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc), .in_rep(in_rep),
        .in_size(in_size), .in_ecx(in_ecx), .in_esi(in_esi), .in_edi(in_edi),
        .in_eflags(in_eflags),
        .it_valid(it_valid), .it_ready(it_ready), .it_opc(it_opc), .it_esi(it_esi),
        .it_edi(it_edi), .it_eflags(it_eflags),
        .it_rsp_valid(it_rsp_valid), .it_rsp_eflags(it_rsp_eflags),
        .done_valid(done_valid), .done_ready(done_ready), .done_ecx(done_ecx),
        .done_esi(done_esi), .done_edi(done_edi), .done_eflags(done_eflags),
        .done_iters(done_iters)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_it(input logic [6:0] opc, input logic [31:0] esi, input logic [31:0] edi,
                           input logic [31:0] fl);
        exp_it_t e;
        e.opc = opc; e.esi = esi; e.edi = edi; e.eflags = fl;
        exp_it.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] ecx, input logic [31:0] esi, input logic [31:0] edi,
                             input logic [31:0] fl, input logic [31:0] iters);
        exp_done_t e;
        e.ecx = ecx; e.esi = esi; e.edi = edi; e.eflags = fl; e.iters = iters;
        exp_done.push_back(e);
    endtask

    task automatic send(input logic [6:0] opc, input logic [1:0] rep, input logic [1:0] size,
                        input logic [31:0] ecx, input logic [31:0] esi, input logic [31:0] edi,
                        input logic [31:0] fl);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end
        in_valid = 1'b1; in_opc = opc; in_rep = rep; in_size = size;
        in_ecx = ecx; in_esi = esi; in_edi = edi; in_eflags = fl;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_done.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL done_timeout: got pending=%0d, expected 0", exp_done.size());
        end
    endtask

    // Responder: one cycle after each issue handshake, return queued EFLAGS.
    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = rst_n && it_valid && it_ready;
            @(posedge clk);
            #1;
            it_rsp_valid = hs;
            if (hs) it_rsp_eflags = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
        end
    end

    initial begin
        exp_it_t e;
        forever begin
            @(negedge clk);
            if (rst_n && it_valid && it_ready) begin
                if (exp_it.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got esi=%h, expected no issue", it_esi);
                end else begin
                    e = exp_it.pop_front();
                    chk("it_opc", {25'h0, it_opc}, {25'h0, e.opc});
                    chk("it_esi", it_esi, e.esi);
                    chk("it_edi", it_edi, e.edi);
                    chk("it_eflags", it_eflags, e.eflags);
                end
            end
        end
    end

    initial begin
        exp_done_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done_valid && done_ready) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got ecx=%h, expected no done", done_ecx);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_ecx", done_ecx, e.ecx);
                    chk("done_esi", done_esi, e.esi);
                    chk("done_edi", done_edi, e.edi);
                    chk("done_eflags", done_eflags, e.eflags);
                    chk("done_iters", done_iters, e.iters);
                end
            end
        end
    end

    initial begin
        int n;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_it_valid", {31'h0, it_valid}, 32'h0);
        chk("rst_done_valid", {31'h0, done_valid}, 32'h0);
        chk("rst_done_esi", done_esi, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // REP MOVS dword, forward
        push_it(CMD_MOVS, 32'h1000, 32'h2000, 32'h2);
        push_it(CMD_MOVS, 32'h1004, 32'h2004, 32'h2);
        push_it(CMD_MOVS, 32'h1008, 32'h2008, 32'h2);
        repeat (3) rsp_q.push_back(32'h2);
        push_done(32'h0, 32'h100C, 32'h200C, 32'h2, 32'd3);
        send(CMD_MOVS, REP_E, SIZE_4B, 32'd3, 32'h1000, 32'h2000, 32'h2);
        wait_done();

        // REP MOVS with ECX=0: CHECK goes straight to DONE
        push_done(32'h0, 32'h3000, 32'h4000, 32'h46, 32'd0);
        send(CMD_MOVS, REP_E, SIZE_4B, 32'd0, 32'h3000, 32'h4000, 32'h46);
        chk("ecx0_done_lat1", {31'h0, done_valid}, 32'h0);
        tick();
        chk("ecx0_done_lat2", {31'h0, done_valid}, 32'h1);
        wait_done();

        // REPE CMPS byte, mismatch on 2nd
        push_it(CMD_CMPS, 32'h10, 32'h20, 32'h02);
        push_it(CMD_CMPS, 32'h11, 32'h21, 32'h46);
        rsp_q.push_back(32'h46);
        rsp_q.push_back(32'h06);
        push_done(32'h3, 32'h12, 32'h22, 32'h06, 32'd2);
        send(CMD_CMPS, REP_E, SIZE_1B, 32'd5, 32'h10, 32'h20, 32'h02);
        wait_done();

        // REPNE CMPS word, DF=1, ESI wraps below zero
        push_it(CMD_CMPS, 32'h0, 32'h100, 32'h402);
        push_it(CMD_CMPS, 32'hFFFF_FFFE, 32'hFE, 32'h402);
        repeat (2) rsp_q.push_back(32'h402);
        push_done(32'h0, 32'hFFFF_FFFC, 32'hFC, 32'h402, 32'd2);
        send(CMD_CMPS, REP_NE, SIZE_2B, 32'd2, 32'h0, 32'h100, 32'h402);
        wait_done();

        // REP encoding 2'b11 behaves as REPE: ZF=0 on first stops
        push_it(CMD_CMPS, 32'h40, 32'h80, 32'h2);
        rsp_q.push_back(32'h2);
        push_done(32'h1, 32'h44, 32'h84, 32'h2, 32'd1);
        send(CMD_CMPS, REP_E_ALT, SIZE_4B, 32'd2, 32'h40, 32'h80, 32'h2);
        wait_done();

        // ADD with REP prefix: one iteration, back-pressure on both sides
        it_ready = 1'b0;
        done_ready = 1'b0;
        push_it(CMD_ADD, 32'h500, 32'h600, 32'h2);
        rsp_q.push_back(32'h97);
        push_done(32'h7, 32'h500, 32'h600, 32'h97, 32'd1);
        send(CMD_ADD, REP_E, SIZE_4B, 32'd7, 32'h500, 32'h600, 32'h2);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("hold_it_valid", {31'h0, it_valid}, 32'h1);
            chk("hold_it_esi", it_esi, 32'h500);
            chk("hold_it_opc", {25'h0, it_opc}, {25'h0, CMD_ADD});
            tick();
        end
        it_ready = 1'b1;
        n = 0;
        while (!done_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("hold_done_valid", {31'h0, done_valid}, 32'h1);
            chk("hold_done_ecx", done_ecx, 32'h7);
            chk("hold_done_eflags", done_eflags, 32'h97);
            tick();
        end
        done_ready = 1'b1;
        wait_done();

        // Reset while waiting for an iteration response
        push_it(CMD_MOVS, 32'h9000, 32'hA000, 32'h2);
        send(CMD_MOVS, REP_E, SIZE_4B, 32'd4, 32'h9000, 32'hA000, 32'h2);
        n = 0;
        while (!it_valid && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("wait_it_valid", {31'h0, it_valid}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_it_valid", {31'h0, it_valid}, 32'h0);
        chk("rst_wait_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_wait_it_esi", it_esi, 32'h0);
        chk("rst_wait_done_ecx", done_ecx, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", {31'h0, done_valid}, 32'h0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // Normal instruction after reset release
        push_it(CMD_MOVS, 32'h7000, 32'h8000, 32'h2);
        rsp_q.push_back(32'h2);
        push_done(32'h0, 32'h7001, 32'h8001, 32'h2, 32'd1);
        send(CMD_MOVS, REP_E, SIZE_1B, 32'd1, 32'h7000, 32'h8000, 32'h2);
        wait_done();
        repeat (4) tick();

        chk("it_queue_drained", exp_it.size(), 32'h0);
        chk("done_queue_drained", exp_done.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rep_sequencer.md
REP_SEQUENCER -- requirements
Module: rep_sequencer

Interface
REQ-001 The parameter SHALL be: ADDR_W, 32, width of ECX/ESI/EDI and iteration counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1, in_ready  out  1: instruction handshake.
REQ-006 in_opc  in  7 (CMD_* encoding); in_rep  in  2 (00 none, 01 REP/REPE, 10 REPNE, 11 = 01); in_size  in  2 (0=1B, 1=2B, 2/3=4B).
REQ-007 in_ecx, in_esi, in_edi  in  ADDR_W; in_eflags  in  32.
REQ-008 it_valid  out  1, it_ready  in  1: iteration issue handshake to the execute/memory path.
REQ-009 it_opc  out  7; it_esi, it_edi  out  ADDR_W; it_eflags  out  32: current iteration state.
REQ-010 it_rsp_valid  in  1, it_rsp_eflags  in  32: iteration completion and resulting EFLAGS.
REQ-011 done_valid  out  1, done_ready  in  1; done_ecx, done_esi, done_edi  out  ADDR_W; done_eflags  out  32; done_iters  out  ADDR_W.

Function
REQ-012 FSM states SHALL be IDLE, CHECK, ISSUE, WAIT, DONE; in_ready SHALL equal (state==IDLE).
REQ-013 IDLE: on in_valid SHALL latch all in_* fields, clear iteration counter, go to CHECK.
REQ-014 is_str SHALL be (opc==CMD_MOVS or opc==CMD_CMPS); rep_eff SHALL be (in_rep!=0 and is_str); rep on non-string opcodes SHALL be ignored (one iteration).
REQ-015 CHECK: rep_eff and ECX==0 SHALL go to DONE with ECX/ESI/EDI/EFLAGS unchanged and done_iters=0; otherwise SHALL go to ISSUE.
REQ-016 ISSUE: it_valid SHALL be 1 with it_* stable until it_ready; on it_valid&&it_ready SHALL go to WAIT.
REQ-017 WAIT: it_rsp_valid SHALL be ignored in all other states; on it_rsp_valid SHALL update EFLAGS<=it_rsp_eflags, iters<=iters+1.
REQ-018 WAIT: for is_str, ESI and EDI SHALL step by size (1/2/4), decrementing if latched DF=1 else incrementing, modulo 2^ADDR_W; non-string ops SHALL leave ESI/EDI unchanged.
REQ-019 WAIT: rep_eff SHALL decrement ECX by 1 (never below 0); non-rep SHALL leave ECX unchanged.
REQ-020 Termination after an iteration SHALL occur if: not rep_eff; or new ECX==0; or CMPS with REPE and response ZF=0; or CMPS with REPNE and response ZF=1. Terminate -> DONE, else -> ISSUE.
REQ-021 ISSUE->WAIT->ISSUE SHALL cost at most 1 idle cycle between iterations (it_valid reasserted the cycle after it_rsp_valid).
REQ-022 DONE: done_valid SHALL be 1 with done_* stable until done_ready; on handshake SHALL go to IDLE; a new in_valid SHALL not be accepted that same cycle.
REQ-023 it_opc SHALL be the latched opcode; it_eflags SHALL be the current accumulated EFLAGS (DF from the latch is never altered by the block).
REQ-024 done_iters SHALL saturate at all-ones rather than wrap.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, clear all registers, drive it_valid=0, done_valid=0, all data outputs 0, in_ready=1 after state settles; reset mid-iteration SHALL abandon the instruction with no done pulse.

Structure
REQ-026 FSM state encoding, rep encoding and size encoding SHALL live in the shared defines header alongside the CMD_* and EFLAGS_* constants.
REQ-027 One sub-module rep_addr_step (size, DF, address -> next address) SHALL be instantiated twice (ESI, EDI).

Verification
REQ-028 REP MOVS size=4, ECX=3, ESI=0x1000, EDI=0x2000, DF=0 -> 3 issues; done ECX=0, ESI=0x100C, EDI=0x200C, iters=3.
REQ-029 REP MOVS ECX=0 -> no it_valid; done in 2 cycles after accept, registers unchanged, iters=0.
REQ-030 REPE CMPS size=1, ECX=5, ZF=0 on 2nd response -> stops; ECX=3, ESI/EDI +2, iters=2.
REQ-031 REPNE CMPS DF=1 size=2, ESI=0x0, ECX=2, ZF=0 twice -> ESI=0xFFFFFFFC (wrap), ECX=0.
REQ-032 ADD with in_rep=01, ECX=7 -> single issue; ECX=7, ESI/EDI unchanged; it_ready held low 4 cycles keeps it_* stable; done_ready low holds done_*.
REQ-033 rst_n asserted in WAIT -> it_valid=0 same cycle, no done_valid; next instruction after release completes normally.
